// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central stall/flush sequencer for the five-stage pipeline.
// Resolves load-use hazards, taken branches resolved in EX, and multi-cycle
// data-memory accesses. It also detects a hung memory (sticky HALT) and keeps
// a saturating count of stalled cycles.
// Control outputs are combinational from state and inputs so that the stage
// registers can sample them on the same edge. All internal storage is registered.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_MemRead,
    input  logic [4:0]       ex_rd,
    input  logic             ex_branch_taken,
    input  logic             mem_MemRead,
    input  logic             mem_MemWrite,
    input  logic             dmem_ready,
    output logic             dmem_req,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_we,
    output logic             memwb_bubble,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } state_t;

    // Last wait-counter value that is still tolerated before declaring a hang.
    localparam logic [15:0]      WAIT_LAST = 16'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STALL_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] STALL_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Load-use hazard: the load in EX writes a register the ID instruction reads.
    // Register 0 is hard-wired, so it never creates a dependency.
    function automatic logic load_use_hit(
        input logic       ld_in_ex,
        input logic [4:0] rd,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       uses_rt
    );
        logic hit;
        hit = ld_in_ex && (rd != 5'd0) &&
              ((rd == rs) || (uses_rt && (rd == rt)));
        return hit;
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic [15:0]      wait_cnt_r;
    logic [CNT_W-1:0] stall_r;
    logic             mem_timeout_r;

    logic memacc_s;
    logic lu_s;

    // Hazard-resolution outputs for a cycle in which the pipeline may advance.
    logic hz_pc_we_s;
    logic hz_ifid_we_s;
    logic hz_ifid_flush_s;
    logic hz_idex_flush_s;

    logic dmem_req_s;
    logic pc_we_s;
    logic ifid_we_s;
    logic ifid_flush_s;
    logic idex_flush_s;
    logic exmem_we_s;
    logic memwb_bubble_s;
    logic wait_clr_s;
    logic wait_inc_s;

    assign memacc_s = mem_MemRead | mem_MemWrite;
    assign lu_s     = load_use_hit(ex_MemRead, ex_rd, id_rs, id_rt, id_uses_rt);

    // Branch/load-use resolution used whenever memory is not holding the pipe.
    always_comb begin
        hz_pc_we_s      = 1'b1;
        hz_ifid_we_s    = 1'b1;
        hz_ifid_flush_s = 1'b0;
        hz_idex_flush_s = 1'b0;
        if (ex_branch_taken) begin
            // The ID instruction is squashed, so a coincident load-use is moot.
            hz_ifid_flush_s = 1'b1;
            hz_idex_flush_s = 1'b1;
        end else if (lu_s) begin
            // Hold PC and IF/ID for one cycle and insert a single bubble in EX.
            hz_pc_we_s      = 1'b0;
            hz_ifid_we_s    = 1'b0;
            hz_idex_flush_s = 1'b1;
        end else begin
            hz_pc_we_s      = 1'b1;
        end
    end

    // Next-state and control-output decode, with reset forcing a safe pattern.
    always_comb begin
        state_nxt_s    = state_r;
        dmem_req_s     = 1'b0;
        pc_we_s        = 1'b1;
        ifid_we_s      = 1'b1;
        ifid_flush_s   = 1'b0;
        idex_flush_s   = 1'b0;
        exmem_we_s     = 1'b1;
        memwb_bubble_s = 1'b0;
        wait_clr_s     = 1'b0;
        wait_inc_s     = 1'b0;
        if (!rst_n) begin
            state_nxt_s    = ST_RUN;
            pc_we_s        = 1'b0;
            ifid_we_s      = 1'b0;
            exmem_we_s     = 1'b0;
            ifid_flush_s   = 1'b1;
            idex_flush_s   = 1'b1;
            memwb_bubble_s = 1'b1;
            dmem_req_s     = 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    dmem_req_s = memacc_s;
                    if (memacc_s && !dmem_ready) begin
                        // Freeze everything up to EX/MEM; WB sees a bubble.
                        pc_we_s        = 1'b0;
                        ifid_we_s      = 1'b0;
                        exmem_we_s     = 1'b0;
                        memwb_bubble_s = 1'b1;
                        wait_clr_s     = 1'b1;
                        state_nxt_s    = ST_MEM_WAIT;
                    end else begin
                        pc_we_s      = hz_pc_we_s;
                        ifid_we_s    = hz_ifid_we_s;
                        ifid_flush_s = hz_ifid_flush_s;
                        idex_flush_s = hz_idex_flush_s;
                        state_nxt_s  = ST_RUN;
                    end
                end
                ST_MEM_WAIT: begin
                    // Request stays up without a gap until the ready cycle.
                    dmem_req_s = 1'b1;
                    if (dmem_ready) begin
                        // Branch or load-use held while frozen is acted on now.
                        pc_we_s      = hz_pc_we_s;
                        ifid_we_s    = hz_ifid_we_s;
                        ifid_flush_s = hz_ifid_flush_s;
                        idex_flush_s = hz_idex_flush_s;
                        state_nxt_s  = ST_RUN;
                    end else begin
                        pc_we_s        = 1'b0;
                        ifid_we_s      = 1'b0;
                        exmem_we_s     = 1'b0;
                        memwb_bubble_s = 1'b1;
                        wait_inc_s     = 1'b1;
                        if (wait_cnt_r == WAIT_LAST) begin
                            state_nxt_s = ST_HALT;
                        end else begin
                            state_nxt_s = ST_MEM_WAIT;
                        end
                    end
                end
                ST_HALT: begin
                    pc_we_s        = 1'b0;
                    ifid_we_s      = 1'b0;
                    exmem_we_s     = 1'b0;
                    memwb_bubble_s = 1'b1;
                    state_nxt_s    = ST_HALT;
                end
                default: begin
                    // An illegal encoding is treated as a hang: freeze the pipe.
                    pc_we_s        = 1'b0;
                    ifid_we_s      = 1'b0;
                    exmem_we_s     = 1'b0;
                    memwb_bubble_s = 1'b1;
                    state_nxt_s    = ST_HALT;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Memory wait counter: cleared on entry to MEM_WAIT, counts each wait cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt_r <= 16'd0;
        end else if (wait_clr_s) begin
            wait_cnt_r <= 16'd0;
        end else if (wait_inc_s) begin
            wait_cnt_r <= wait_cnt_r + 16'd1;
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Saturating stall counter: counts held-PC cycles outside HALT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_r <= {CNT_W{1'b0}};
        end else if (!pc_we_s && (state_r != ST_HALT) && (stall_r != STALL_MAX)) begin
            stall_r <= stall_r + STALL_ONE;
        end else begin
            stall_r <= stall_r;
        end
    end

    // Sticky hung-memory flag, set on the edge that enters HALT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_timeout_r <= 1'b0;
        end else if (state_nxt_s == ST_HALT) begin
            mem_timeout_r <= 1'b1;
        end else begin
            mem_timeout_r <= mem_timeout_r;
        end
    end

    assign dmem_req     = dmem_req_s;
    assign pc_we        = pc_we_s;
    assign ifid_we      = ifid_we_s;
    assign ifid_flush   = ifid_flush_s;
    assign idex_flush   = idex_flush_s;
    assign exmem_we     = exmem_we_s;
    assign memwb_bubble = memwb_bubble_s;
    assign mem_timeout  = mem_timeout_r;
    assign stall_cycles = stall_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl. Inputs change on the
// falling edge; outputs are checked 1 time unit later, away from the rising edge.
// Control vector bit order:
//   {dmem_req, pc_we, ifid_we, ifid_flush, idex_flush, exmem_we, memwb_bubble, mem_timeout}
module tb_pipe_hazard_ctrl;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 4;

    // Expected control patterns.
    localparam logic [7:0] C_IDLE   = 8'b0110_0100;
    localparam logic [7:0] C_LU     = 8'b0000_1100;
    localparam logic [7:0] C_BR     = 8'b0111_1100;
    localparam logic [7:0] C_MSTALL = 8'b1000_0010;
    localparam logic [7:0] C_MRDY   = 8'b1110_0100;
    localparam logic [7:0] C_MRDYBR = 8'b1111_1100;
    localparam logic [7:0] C_HALT   = 8'b0000_0011;
    localparam logic [7:0] C_RST    = 8'b0001_1010;

    logic             clk;
    logic             rst_n;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             ex_MemRead;
    logic [4:0]       ex_rd;
    logic             ex_branch_taken;
    logic             mem_MemRead;
    logic             mem_MemWrite;
    logic             dmem_ready;
    logic             dmem_req;
    logic             pc_we;
    logic             ifid_we;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_we;
    logic             memwb_bubble;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles;
    logic [7:0]       ctl;

    int checks;
    int failures;

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_uses_rt     (id_uses_rt),
        .ex_MemRead     (ex_MemRead),
        .ex_rd          (ex_rd),
        .ex_branch_taken(ex_branch_taken),
        .mem_MemRead    (mem_MemRead),
        .mem_MemWrite   (mem_MemWrite),
        .dmem_ready     (dmem_ready),
        .dmem_req       (dmem_req),
        .pc_we          (pc_we),
        .ifid_we        (ifid_we),
        .ifid_flush     (ifid_flush),
        .idex_flush     (idex_flush),
        .exmem_we       (exmem_we),
        .memwb_bubble   (memwb_bubble),
        .mem_timeout    (mem_timeout),
        .stall_cycles   (stall_cycles)
    );

    assign ctl = {dmem_req, pc_we, ifid_we, ifid_flush, idex_flush, exmem_we, memwb_bubble, mem_timeout};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic [7:0] exp);
        chk(tag, {24'd0, ctl}, {24'd0, exp});
    endtask

    task automatic chk_cnt(input string tag, input int exp);
        chk(tag, {28'd0, stall_cycles}, 32'(exp));
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        rst_n           = 1'b0;
        id_rs           = 5'd0;
        id_rt           = 5'd0;
        id_uses_rt      = 1'b0;
        ex_MemRead      = 1'b0;
        ex_rd           = 5'd0;
        ex_branch_taken = 1'b0;
        mem_MemRead     = 1'b0;
        mem_MemWrite    = 1'b0;
        dmem_ready      = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state and forced outputs.
        @(negedge clk); #1;
        chk_ctl("reset_ctl", C_RST);
        chk_cnt("reset_stall", 0);
        rst_n = 1'b1; #1;
        chk_ctl("run_idle", C_IDLE);

        // Load-use on rs: exactly one stall cycle.
        @(negedge clk);
        ex_MemRead = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; #1;
        chk_ctl("lu_rs", C_LU);
        @(negedge clk);
        ex_MemRead = 1'b0; #1;
        chk_ctl("lu_release", C_IDLE);
        chk_cnt("lu_count", 1);

        // No hazard through register 0.
        @(negedge clk);
        ex_MemRead = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_rt = 5'd0; #1;
        chk_ctl("lu_r0", C_IDLE);

        // rt match ignored when rt is not read.
        @(negedge clk);
        ex_rd = 5'd5; id_rs = 5'd3; id_rt = 5'd5; id_uses_rt = 1'b0; #1;
        chk_ctl("lu_rt_unused", C_IDLE);

        // rt match when rt is read.
        @(negedge clk);
        id_uses_rt = 1'b1; #1;
        chk_ctl("lu_rt", C_LU);

        // Branch with coincident load-use: squash, no stall.
        @(negedge clk);
        ex_branch_taken = 1'b1; #1;
        chk_ctl("br_lu", C_BR);
        chk_cnt("br_pre_count", 2);
        @(negedge clk);
        ex_branch_taken = 1'b0; ex_MemRead = 1'b0; ex_rd = 5'd0;
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; #1;
        chk_ctl("br_after", C_IDLE);
        chk_cnt("br_no_stall", 2);

        // Memory read with 3 not-ready cycles, branch arriving while frozen.
        @(negedge clk);
        mem_MemRead = 1'b1; dmem_ready = 1'b0; #1;
        chk_ctl("mw_req_run", C_MSTALL);
        @(negedge clk); #1;
        chk_ctl("mw_wait1", C_MSTALL);
        @(negedge clk);
        ex_branch_taken = 1'b1; #1;
        chk_ctl("mw_wait2_br_held", C_MSTALL);
        @(negedge clk);
        dmem_ready = 1'b1; #1;
        chk_ctl("mw_ready_br", C_MRDYBR);
        chk_cnt("mw_count", 5);
        @(negedge clk);
        mem_MemRead = 1'b0; dmem_ready = 1'b0; ex_branch_taken = 1'b0; #1;
        chk_ctl("mw_done", C_IDLE);
        chk_cnt("mw_count_hold", 5);

        // Zero-wait store, then ready ignored without a request.
        @(negedge clk);
        mem_MemWrite = 1'b1; dmem_ready = 1'b1; #1;
        chk_ctl("store_zero_wait", C_MRDY);
        @(negedge clk);
        mem_MemWrite = 1'b0; #1;
        chk_ctl("ready_no_req", C_IDLE);
        chk_cnt("zero_wait_count", 5);

        // Timeout: one RUN request cycle, then MEM_TIMEOUT wait cycles, then HALT.
        @(negedge clk);
        dmem_ready = 1'b0; mem_MemRead = 1'b1; #1;
        chk_ctl("to_req_run", C_MSTALL);
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            @(negedge clk); #1;
            chk_ctl("to_wait", C_MSTALL);
        end
        @(negedge clk); #1;
        chk_ctl("to_halt", C_HALT);
        chk_cnt("to_count", 10);
        dmem_ready = 1'b1; #1;
        chk_ctl("to_halt_ready", C_HALT);
        @(negedge clk);
        mem_MemRead = 1'b0; dmem_ready = 1'b0; #1;
        chk_ctl("to_halt_sticky", C_HALT);
        chk_cnt("to_count_frozen", 10);
        @(negedge clk);
        rst_n = 1'b0; #1;
        chk({31'd0, pc_we}, {31'd0, pc_we}, 32'd0);
        chk("to_rst_req", {31'd0, dmem_req}, 32'd0);
        chk("to_rst_flush", {31'd0, ifid_flush}, 32'd1);
        @(negedge clk); #1;
        chk_ctl("to_after_reset", C_RST);
        chk_cnt("to_reset_count", 0);
        rst_n = 1'b1; #1;
        chk_ctl("to_run_again", C_IDLE);

        // Reset in the second MEM_WAIT cycle abandons the access.
        @(negedge clk);
        mem_MemRead = 1'b1; #1;
        chk_ctl("rmw_req", C_MSTALL);
        @(negedge clk); #1;
        chk_ctl("rmw_wait1", C_MSTALL);
        @(negedge clk);
        rst_n = 1'b0; #1;
        chk_ctl("rmw_reset_forced", C_RST);
        @(negedge clk);
        rst_n = 1'b1; mem_MemRead = 1'b0; #1;
        chk_ctl("rmw_no_req", C_IDLE);
        chk_cnt("rmw_count", 0);

        // Saturation of the stall counter under a held load-use.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            ex_MemRead = 1'b1; ex_rd = 5'd7; id_rs = 5'd7; #1;
            if (i == 14) begin
                chk_cnt("sat_pre", 14);
            end
        end
        @(negedge clk);
        ex_MemRead = 1'b0; #1;
        chk_ctl("sat_release", C_IDLE);
        chk_cnt("sat_max", 15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
